// File: rtl/video_write_buffer.sv
// Show-ahead write FIFO between the CPU bus and the video side: captures in-window CPU writes
// and drains them over vValid/vReady. Optional tail coalescing: VIDEO_WRITE_COALESCE_EN.
module video_write_buffer #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 8,
  parameter logic [ADDR_W-1:0] WIN_LO = 16'h8000,
  parameter logic [ADDR_W-1:0] WIN_HI = 16'hF530
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            cAddress,
  input  logic [DATA_W-1:0]            cData,
  input  logic                         cWrite,
  output logic                         cStall,
  output logic [ADDR_W-1:0]            vAddress,
  output logic [DATA_W-1:0]            vData,
  output logic                         vValid,
  input  logic                         vReady,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         ovfClear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  logic [PTR_W-1:0] rdPtr, wrPtr, rdPtrNext, wrPtrNext, wrIdx;
  logic [CNT_W-1:0] count, countNext;
  logic             inWin, req, pop, push, drop, coal, memWr, full;
  logic [ADDR_W-1:0] headAddrNext;
  logic [DATA_W-1:0] headDataNext;

  assign full   = (count == FULL_CNT);
  assign inWin  = (cAddress >= WIN_LO) && (cAddress <= WIN_HI);
  assign req    = cWrite && inWin;
  assign vValid = (count != '0);
  assign cStall = full;
  assign level  = count;
  assign pop    = vValid && vReady;

`ifdef VIDEO_WRITE_COALESCE_EN
  logic [PTR_W-1:0] tailIdx;
  assign tailIdx = wrPtr - PTR_W'(1);
  // Never merge into a lone entry that is leaving this cycle.
  assign coal  = req && (count != '0) && (cAddress == addrMem[tailIdx])
                 && ((count != CNT_W'(1)) || !pop);
  assign wrIdx = coal ? tailIdx : wrPtr;
`else
  assign coal  = 1'b0;
  assign wrIdx = wrPtr;
`endif

  assign push  = req && !coal && (!full || pop);
  assign drop  = req && !coal && full && !pop;
  assign memWr = push || coal;

  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
    rdPtrNext = pop  ? rdPtr + PTR_W'(1) : rdPtr;
    wrPtrNext = push ? wrPtr + PTR_W'(1) : wrPtr;
    // The new head may be the slot written this very edge; forward it from the bus.
    if (memWr && (wrIdx == rdPtrNext)) begin
      headAddrNext = cAddress;
      headDataNext = cData;
    end else begin
      headAddrNext = addrMem[rdPtrNext];
      headDataNext = dataMem[rdPtrNext];
    end
  end

  always_ff @(posedge clk) begin
    if (memWr) begin
      addrMem[wrIdx] <= cAddress;
      dataMem[wrIdx] <= cData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      overflow <= 1'b0;
      vAddress <= '0;
      vData    <= '0;
    end else begin
      count <= countNext;
      rdPtr <= rdPtrNext;
      wrPtr <= wrPtrNext;
      if (drop)          overflow <= 1'b1;
      else if (ovfClear) overflow <= 1'b0;
      if (countNext != '0) begin
        vAddress <= headAddrNext;
        vData    <= headDataNext;
      end
    end
  end

endmodule

// File: tb/tb_video_write_buffer.sv
// Directed self-checking bench for video_write_buffer (default DEPTH=8, window 0x8000..0xF530).
module tb_video_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cAddress = '0;
  logic [7:0]  cData = '0;
  logic        cWrite = 1'b0;
  logic        cStall;
  logic [15:0] vAddress;
  logic [7:0]  vData;
  logic        vValid;
  logic        vReady = 1'b0;
  logic [3:0]  level;
  logic        overflow;
  logic        ovfClear = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  video_write_buffer dut (
    .clk(clk), .rst_n(rst_n), .cAddress(cAddress), .cData(cData), .cWrite(cWrite),
    .cStall(cStall), .vAddress(vAddress), .vData(vData), .vValid(vValid),
    .vReady(vReady), .level(level), .overflow(overflow), .ovfClear(ovfClear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cAddress = a; cData = d; cWrite = 1'b1;
    tick();
    cWrite = 1'b0;
  endtask

  task automatic drainAll();
    vReady = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vReady = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nChecks++; if (vValid !== 1'b0) begin nFails++; $display("FAIL reset_vValid got %b exp 0", vValid); end
    nChecks++; if (cStall !== 1'b0) begin nFails++; $display("FAIL reset_cStall got %b exp 0", cStall); end
    nChecks++; if (level !== 4'd0) begin nFails++; $display("FAIL reset_level got %0d exp 0", level); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    nChecks++; if (vAddress !== 16'h0000) begin nFails++; $display("FAIL reset_vAddress got %h exp 0000", vAddress); end
    nChecks++; if (vData !== 8'h00) begin nFails++; $display("FAIL reset_vData got %h exp 00", vData); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wr(16'h8000, 8'hAA);
    nChecks++; if (vValid !== 1'b1) begin nFails++; $display("FAIL basic_vValid got %b exp 1", vValid); end
    nChecks++; if (vAddress !== 16'h8000) begin nFails++; $display("FAIL basic_vAddress got %h exp 8000", vAddress); end
    nChecks++; if (vData !== 8'hAA) begin nFails++; $display("FAIL basic_vData got %h exp aa", vData); end
    nChecks++; if (level !== 4'd1) begin nFails++; $display("FAIL basic_level got %0d exp 1", level); end
    vReady = 1'b1;
    tick();
    vReady = 1'b0;
    nChecks++; if (vValid !== 1'b0) begin nFails++; $display("FAIL basic_empty got %b exp 0", vValid); end
  endtask

  task automatic test_window();
    wr(16'h7FFF, 8'h01);
    wr(16'hF531, 8'h02);
    wr(16'hF530, 8'h03);
    nChecks++; if (level !== 4'd1) begin nFails++; $display("FAIL window_level got %0d exp 1", level); end
    nChecks++; if (vAddress !== 16'hF530) begin nFails++; $display("FAIL window_vAddress got %h exp f530", vAddress); end
    nChecks++; if (vData !== 8'h03) begin nFails++; $display("FAIL window_vData got %h exp 03", vData); end
    drainAll();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) wr(16'h8000 + 16'(i), 8'(8'h40 + i));
    nChecks++; if (cStall !== 1'b1) begin nFails++; $display("FAIL full_cStall got %b exp 1", cStall); end
    nChecks++; if (level !== 4'd8) begin nFails++; $display("FAIL full_level got %0d exp 8", level); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL full_ovf_early got %b exp 0", overflow); end
    wr(16'h8008, 8'h48);
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL drop_overflow got %b exp 1", overflow); end
    nChecks++; if (level !== 4'd8) begin nFails++; $display("FAIL drop_level got %0d exp 8", level); end
    // dropped write and a clear in the same cycle: set wins
    ovfClear = 1'b1;
    wr(16'h8009, 8'h49);
    ovfClear = 1'b0;
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_priority got %b exp 1", overflow); end
    wr(16'h0010, 8'h50);
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_outwin got %b exp 1", overflow); end
    vReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nChecks++; if (vValid !== 1'b1 || vAddress !== 16'h8000 + 16'(i) || vData !== 8'(8'h40 + i)) begin
        nFails++; $display("FAIL drain_%0d got v=%b %h/%h exp 1 %h/%h", i, vValid, vAddress, vData, 16'h8000 + 16'(i), 8'(8'h40 + i));
      end
      tick();
    end
    vReady = 1'b0;
    nChecks++; if (vValid !== 1'b0) begin nFails++; $display("FAIL drain_empty got %b exp 0", vValid); end
    nChecks++; if (cStall !== 1'b0) begin nFails++; $display("FAIL drain_cStall got %b exp 0", cStall); end
    ovfClear = 1'b1;
    tick();
    ovfClear = 1'b0;
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) wr(16'h8100 + 16'(i), 8'(8'h10 + i));
    vReady = 1'b1;
    wr(16'h9000, 8'h55);
    vReady = 1'b0;
    nChecks++; if (level !== 4'd8) begin nFails++; $display("FAIL pp_level got %0d exp 8", level); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL pp_overflow got %b exp 0", overflow); end
    vReady = 1'b1;
    for (int i = 1; i < 9; i++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      ea = (i == 8) ? 16'h9000 : 16'h8100 + 16'(i);
      ed = (i == 8) ? 8'h55 : 8'(8'h10 + i);
      nChecks++; if (vValid !== 1'b1 || vAddress !== ea || vData !== ed) begin
        nFails++; $display("FAIL pp_drain_%0d got v=%b %h/%h exp 1 %h/%h", i, vValid, vAddress, vData, ea, ed);
      end
      tick();
    end
    vReady = 1'b0;
    nChecks++; if (vValid !== 1'b0) begin nFails++; $display("FAIL pp_empty got %b exp 0", vValid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) wr(16'hA100 + 16'(i), 8'(i));
    vReady = 1'b1;
    tick(); tick();
    vReady = 1'b0;
    nChecks++; if (level !== 4'd5) begin nFails++; $display("FAIL mid_level_pre got %0d exp 5", level); end
    rst_n = 1'b0;
    #2;
    nChecks++; if (vValid !== 1'b0) begin nFails++; $display("FAIL mid_vValid got %b exp 0", vValid); end
    nChecks++; if (level !== 4'd0) begin nFails++; $display("FAIL mid_level got %0d exp 0", level); end
    #2;
    rst_n = 1'b1;
    tick();
    wr(16'hB000, 8'h77);
    nChecks++; if (vValid !== 1'b1 || vAddress !== 16'hB000 || vData !== 8'h77 || level !== 4'd1) begin
      nFails++; $display("FAIL mid_after got v=%b %h/%h l=%0d exp 1 b000/77 l=1", vValid, vAddress, vData, level);
    end
    drainAll();
  endtask

  task automatic test_coalesce();
    wr(16'hA000, 8'h11);
    wr(16'hA000, 8'h22);
`ifdef VIDEO_WRITE_COALESCE_EN
    nChecks++; if (level !== 4'd1 || vData !== 8'h22) begin
      nFails++; $display("FAIL coal_on got l=%0d d=%h exp l=1 d=22", level, vData);
    end
`else
    nChecks++; if (level !== 4'd2 || vData !== 8'h11) begin
      nFails++; $display("FAIL coal_off_first got l=%0d d=%h exp l=2 d=11", level, vData);
    end
    vReady = 1'b1;
    tick();
    vReady = 1'b0;
    nChecks++; if (vValid !== 1'b1 || vData !== 8'h22 || vAddress !== 16'hA000) begin
      nFails++; $display("FAIL coal_off_second got v=%b %h/%h exp 1 a000/22", vValid, vAddress, vData);
    end
`endif
    drainAll();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_coalesce();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
